// File: rtl/spi_accel_pkg.sv
// rtl/spi_accel_pkg.sv - register map, command bit positions, FSM states and reset values
package spi_accel_pkg;

  localparam logic [5:0] ADDR_DEVID      = 6'h00;
  localparam logic [5:0] ADDR_BW_RATE    = 6'h2C;
  localparam logic [5:0] ADDR_INT_ENABLE = 6'h2E;
  localparam logic [5:0] ADDR_INT_MAP    = 6'h2F;
  localparam logic [5:0] ADDR_INT_SOURCE = 6'h30;
  localparam logic [5:0] ADDR_DATAX0     = 6'h32;
  localparam logic [5:0] ADDR_DATAX1     = 6'h33;
  localparam logic [5:0] ADDR_DATAY0     = 6'h34;
  localparam logic [5:0] ADDR_DATAY1     = 6'h35;
  localparam logic [5:0] ADDR_DATAZ0     = 6'h36;
  localparam logic [5:0] ADDR_DATAZ1     = 6'h37;

  localparam int CMD_RW_BIT     = 7;
  localparam int CMD_MB_BIT     = 6;
  localparam int DATA_READY_BIT = 7;

  localparam logic [7:0] RST_BW_RATE    = 8'h0A;
  localparam logic [7:0] RST_INT_SOURCE = 8'h02;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA
  } spi_state_e;

  function automatic logic is_read_only(input logic [5:0] a);
    return (a == ADDR_DEVID) || (a == ADDR_INT_SOURCE) ||
           ((a >= ADDR_DATAX0) && (a <= ADDR_DATAZ1));
  endfunction

endpackage

// File: rtl/spi_accel_target_if.sv
// rtl/spi_accel_target_if.sv - SPI pins, sample input and register-write/interrupt outputs
interface spi_accel_target_if;
  logic        SPI_CLK;
  logic        SPI_CSN;
  logic        SPI_SDI;
  logic        SPI_SDO;
  logic        sample_valid;
  logic [15:0] sample_x;
  logic [15:0] sample_y;
  logic        reg_wr_valid;
  logic [5:0]  reg_wr_addr;
  logic [7:0]  reg_wr_data;
  logic [1:0]  interrupt;

  modport slave (
    input  SPI_CLK, SPI_CSN, SPI_SDI, sample_valid, sample_x, sample_y,
    output SPI_SDO, reg_wr_valid, reg_wr_addr, reg_wr_data, interrupt
  );

  modport master (
    output SPI_CLK, SPI_CSN, SPI_SDI, sample_valid, sample_x, sample_y,
    input  SPI_SDO, reg_wr_valid, reg_wr_addr, reg_wr_data, interrupt
  );
endinterface

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - multi-stage synchronizers for SPI pins with SCLK/CSN edge pulses
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sclk,
  input  logic i_csn,
  input  logic i_sdi,
  output logic o_sdi,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_csn_rise,
  output logic o_csn_fall
);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_csn_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic                   r_sclk_prev;
  logic                   r_csn_prev;

  // CSN chain resets low so a CSN held low across reset release cannot fake a falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '1;
      r_csn_sync  <= '0;
      r_sdi_sync  <= '0;
      r_sclk_prev <= 1'b1;
      r_csn_prev  <= 1'b0;
    end else begin
      r_sclk_sync <= (r_sclk_sync << 1) | SYNC_STAGES'(i_sclk);
      r_csn_sync  <= (r_csn_sync << 1) | SYNC_STAGES'(i_csn);
      r_sdi_sync  <= (r_sdi_sync << 1) | SYNC_STAGES'(i_sdi);
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
      r_csn_prev  <= r_csn_sync[SYNC_STAGES-1];
    end
  end

  assign o_sdi       = r_sdi_sync[SYNC_STAGES-1];
  assign o_sclk_rise =  r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
  assign o_sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] &  r_sclk_prev;
  assign o_csn_rise  =  r_csn_sync[SYNC_STAGES-1]  & ~r_csn_prev;
  assign o_csn_fall  = ~r_csn_sync[SYNC_STAGES-1]  &  r_csn_prev;

endmodule

// File: rtl/spi_accel_target.sv
// rtl/spi_accel_target.sv - SPI mode-3 accelerometer register target with tear-free sample commit
// Define SPI_ACCEL_TARGET_MULTIBYTE_EN to honour the MB command bit (address auto-increment).
module spi_accel_target
  import spi_accel_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEVID       = 8'hE5
) (
  input logic                clk,
  input logic                reset,
  spi_accel_target_if.slave  bus
);

  logic w_sdi, w_sclk_rise, w_sclk_fall, w_csn_rise, w_csn_fall;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk         (clk),
    .rst         (reset),
    .i_sclk      (bus.SPI_CLK),
    .i_csn       (bus.SPI_CSN),
    .i_sdi       (bus.SPI_SDI),
    .o_sdi       (w_sdi),
    .o_sclk_rise (w_sclk_rise),
    .o_sclk_fall (w_sclk_fall),
    .o_csn_rise  (w_csn_rise),
    .o_csn_fall  (w_csn_fall)
  );

  spi_state_e  r_state, w_state_next;
  logic [2:0]  r_bit_cnt;
  logic [6:0]  r_rx_shift;
  logic [7:0]  r_tx_shift;
  logic        r_sdo, r_rw, r_mb, r_byte_en;
  logic [5:0]  r_addr;
  logic [7:0]  r_regs [64];
  logic [7:0]  r_int_source;
  logic [15:0] r_pend_x, r_pend_y, r_data_x, r_data_y;
  logic        r_pend_valid;
  logic        r_wr_valid;
  logic [5:0]  r_wr_addr;
  logic [7:0]  r_wr_data;
  logic [1:0]  r_irq;

  logic [7:0]  w_rx_byte, w_rd_data;
  logic [5:0]  w_next_addr;
  logic        w_byte_done, w_cmd_done, w_data_done, w_commit, w_src_clr, w_mb_en;
  logic [7:0]  w_int_active;

`ifdef SPI_ACCEL_TARGET_MULTIBYTE_EN
  assign w_mb_en = r_mb;
`else
  assign w_mb_en = 1'b0;
`endif

  assign w_rx_byte   = {r_rx_shift, w_sdi};
  assign w_byte_done = w_sclk_rise && !w_csn_rise && (r_bit_cnt == 3'd7) && (r_state != ST_IDLE);
  assign w_cmd_done  = w_byte_done && (r_state == ST_CMD);
  assign w_data_done = w_byte_done && (r_state == ST_DATA) && r_byte_en;
  assign w_next_addr = w_cmd_done ? w_rx_byte[5:0] : r_addr + 6'd1;
  assign w_commit    = (r_state == ST_IDLE) && r_pend_valid;
  assign w_src_clr   = w_data_done && r_rw && (r_addr == ADDR_INT_SOURCE);

  always_comb begin
    w_rd_data = r_regs[w_next_addr];
    case (w_next_addr)
      ADDR_DEVID:              w_rd_data = DEVID;
      ADDR_INT_SOURCE:         w_rd_data = r_int_source;
      ADDR_DATAX0:             w_rd_data = r_data_x[7:0];
      ADDR_DATAX1:             w_rd_data = r_data_x[15:8];
      ADDR_DATAY0:             w_rd_data = r_data_y[7:0];
      ADDR_DATAY1:             w_rd_data = r_data_y[15:8];
      ADDR_DATAZ0, ADDR_DATAZ1: w_rd_data = 8'h00;
      default:                 ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_csn_fall) w_state_next = ST_CMD;
      ST_CMD:  if (w_cmd_done) w_state_next = ST_DATA;
      ST_DATA: ;
      default: w_state_next = ST_IDLE;
    endcase
    if (w_csn_rise) w_state_next = ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_sdo      <= 1'b0;
      r_rw       <= 1'b0;
      r_mb       <= 1'b0;
      r_byte_en  <= 1'b0;
      r_addr     <= '0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      for (int i = 0; i < 64; i++) r_regs[i] <= 8'h00;
      r_regs[ADDR_BW_RATE] <= RST_BW_RATE;
    end else begin
      r_wr_valid <= 1'b0;
      if (w_csn_rise || r_state == ST_IDLE) begin
        r_bit_cnt  <= '0;
        r_sdo      <= 1'b0;
        r_tx_shift <= '0;
        r_byte_en  <= 1'b0;
      end else begin
        if (w_sclk_rise) begin
          r_bit_cnt  <= r_bit_cnt + 3'd1;
          r_rx_shift <= w_rx_byte[6:0];
        end
        if (w_sclk_fall && r_state == ST_DATA) begin
          r_sdo      <= r_tx_shift[7];
          r_tx_shift <= {r_tx_shift[6:0], 1'b0};
        end
        if (w_cmd_done) begin
          r_rw       <= w_rx_byte[CMD_RW_BIT];
          r_mb       <= w_rx_byte[CMD_MB_BIT];
          r_addr     <= w_next_addr;
          r_byte_en  <= 1'b1;
          r_tx_shift <= w_rx_byte[CMD_RW_BIT] ? w_rd_data : 8'h00;
        end
        if (w_data_done) begin
          if (!r_rw && !is_read_only(r_addr)) begin
            r_regs[r_addr] <= w_rx_byte;
            r_wr_valid     <= 1'b1;
            r_wr_addr      <= r_addr;
            r_wr_data      <= w_rx_byte;
          end
          r_byte_en  <= w_mb_en;
          r_addr     <= w_next_addr;
          r_tx_shift <= (w_mb_en && r_rw) ? w_rd_data : 8'h00;
        end
      end
    end
  end

  assign w_int_active = r_int_source & r_regs[ADDR_INT_ENABLE];

  // Samples land in the data registers only between frames; DATA_READY set beats a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_x     <= '0;
      r_pend_y     <= '0;
      r_pend_valid <= 1'b0;
      r_data_x     <= '0;
      r_data_y     <= '0;
      r_int_source <= RST_INT_SOURCE;
      r_irq        <= 2'b00;
    end else begin
      if (bus.sample_valid) begin
        r_pend_x     <= bus.sample_x;
        r_pend_y     <= bus.sample_y;
        r_pend_valid <= 1'b1;
      end else if (w_commit) begin
        r_pend_valid <= 1'b0;
      end
      if (w_commit) begin
        r_data_x <= r_pend_x;
        r_data_y <= r_pend_y;
      end
      if (w_src_clr) r_int_source[DATA_READY_BIT] <= 1'b0;
      if (w_commit)  r_int_source[DATA_READY_BIT] <= 1'b1;
      r_irq[0] <= |(w_int_active & ~r_regs[ADDR_INT_MAP]);
      r_irq[1] <= |(w_int_active &  r_regs[ADDR_INT_MAP]);
    end
  end

  assign bus.SPI_SDO      = r_sdo;
  assign bus.reg_wr_valid = r_wr_valid;
  assign bus.reg_wr_addr  = r_wr_addr;
  assign bus.reg_wr_data  = r_wr_data;
  assign bus.interrupt    = r_irq;

endmodule

// File: tb/tb_spi_accel_target.sv
// tb/tb_spi_accel_target.sv - directed self-checking bench for spi_accel_target
module tb_spi_accel_target;

  logic clk = 1'b0;
  logic reset = 1'b1;
  spi_accel_target_if bus ();

  spi_accel_target #(.SYNC_STAGES(2), .DEVID(8'hE5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         wr_cnt   = 0;
  int         exp_wr   = 0;
  logic [5:0] wr_addr_seen = '0;
  logic [7:0] wr_data_seen = '0;
  logic [7:0] rd;

  always @(negedge clk) begin
    if (!reset && bus.reg_wr_valid) begin
      wr_cnt++;
      wr_addr_seen = bus.reg_wr_addr;
      wr_data_seen = bus.reg_wr_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mode 3: master drives SDI on falling edge, samples SDO just before the rising edge
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      bus.SPI_CLK = 1'b0;
      bus.SPI_SDI = tx[i];
      #50;
      rx[i] = bus.SPI_SDO;
      bus.SPI_CLK = 1'b1;
      #50;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic spi_begin();
    bus.SPI_CSN = 1'b0;
    #100;
  endtask

  task automatic spi_end();
    #100;
    bus.SPI_CSN = 1'b1;
    #200;
  endtask

  task automatic reg_write(input logic [5:0] addr, input logic [7:0] data);
    logic [7:0] dummy;
    spi_begin();
    spi_byte({2'b00, addr}, dummy);
    spi_byte(data, dummy);
    spi_end();
  endtask

  task automatic reg_read(input logic [5:0] addr, output logic [7:0] data);
    logic [7:0] dummy;
    spi_begin();
    spi_byte({2'b10, addr}, dummy);
    spi_byte(8'h00, data);
    spi_end();
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    bus.sample_x = x;
    bus.sample_y = y;
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    bus.SPI_CLK = 1'b1;
    bus.SPI_CSN = 1'b1;
    bus.SPI_SDI = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_x = 16'h0000;
    bus.sample_y = 16'h0000;

    repeat (3) @(negedge clk);
    chk("rst_sdo", bus.SPI_SDO, 1'b0);
    chk("rst_wr_valid", bus.reg_wr_valid, 1'b0);
    chk("rst_wr_addr", bus.reg_wr_addr, 6'h00);
    chk("rst_wr_data", bus.reg_wr_data, 8'h00);
    chk("rst_irq", bus.interrupt, 2'b00);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    reg_write(6'h2D, 8'h08);
    exp_wr++;
    chk("wr2d_pulses", wr_cnt, exp_wr);
    chk("wr2d_addr", wr_addr_seen, 6'h2D);
    chk("wr2d_data", wr_data_seen, 8'h08);
    reg_read(6'h2D, rd);
    chk("rd2d", rd, 8'h08);

    reg_read(6'h00, rd);
    chk("rd_devid", rd, 8'hE5);
    chk("sdo_idle", bus.SPI_SDO, 1'b0);
    reg_write(6'h00, 8'h11);
    chk("wr_ro_nopulse", wr_cnt, exp_wr);
    reg_read(6'h00, rd);
    chk("rd_devid_again", rd, 8'hE5);

    reg_read(6'h2C, rd);
    chk("rd_bw_rate_rst", rd, 8'h0A);
    reg_read(6'h30, rd);
    chk("rd_int_src_rst", rd, 8'h02);
    reg_read(6'h3A, rd);
    chk("rd_unwritten", rd, 8'h00);

    spi_begin();
    spi_byte(8'hEC, rd);
    spi_byte(8'h00, rd);
    chk("mb_byte0", rd, 8'h0A);
    spi_byte(8'h00, rd);
`ifdef SPI_ACCEL_TARGET_MULTIBYTE_EN
    chk("mb_byte1", rd, 8'h08);
`else
    chk("mb_byte1_ignored", rd, 8'h00);
`endif
    spi_end();

    reg_write(6'h2E, 8'h80);
    reg_write(6'h2F, 8'h80);
    exp_wr += 2;
    chk("int_cfg_pulses", wr_cnt, exp_wr);
    chk("irq_before_sample", bus.interrupt, 2'b00);
    pulse_sample(16'h1234, 16'hFEDC);
    chk("irq_after_sample", bus.interrupt, 2'b10);
    reg_read(6'h30, rd);
    chk("rd_int_src_set", rd, 8'h82);
    chk("irq_after_clear", bus.interrupt, 2'b00);

`ifdef SPI_ACCEL_TARGET_MULTIBYTE_EN
    spi_begin();
    spi_byte(8'hF2, rd);
    spi_byte(8'h00, rd);
    chk("x_lo", rd, 8'h34);
    spi_byte(8'h00, rd);
    chk("x_hi", rd, 8'h12);
    spi_byte(8'h00, rd);
    chk("y_lo", rd, 8'hDC);
    spi_byte(8'h00, rd);
    chk("y_hi", rd, 8'hFE);
    spi_end();
`else
    reg_read(6'h32, rd);
    chk("x_lo", rd, 8'h34);
    reg_read(6'h33, rd);
    chk("x_hi", rd, 8'h12);
    reg_read(6'h34, rd);
    chk("y_lo", rd, 8'hDC);
    reg_read(6'h35, rd);
    chk("y_hi", rd, 8'hFE);
`endif
    reg_read(6'h36, rd);
    chk("z_lo_zero", rd, 8'h00);

    spi_begin();
    pulse_sample(16'h5678, 16'h9ABC);
    spi_byte(8'hB2, rd);
    spi_byte(8'h00, rd);
    chk("torn_old_x", rd, 8'h34);
    spi_end();
    reg_read(6'h32, rd);
    chk("new_x_lo", rd, 8'h78);
    reg_read(6'h35, rd);
    chk("new_y_hi", rd, 8'h9A);

    spi_begin();
    spi_byte(8'h2E, rd);
    spi_bits(8'h00, 4, rd);
    spi_end();
    chk("partial_nopulse", wr_cnt, exp_wr);
    reg_read(6'h2E, rd);
    chk("partial_unchanged", rd, 8'h80);

    spi_begin();
    spi_bits(8'hAD, 4, rd);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_sdo", bus.SPI_SDO, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    bus.SPI_CLK = 1'b1;
    #100;
    bus.SPI_CSN = 1'b1;
    #200;
    reg_read(6'h2D, rd);
    chk("midrst_2d_reset", rd, 8'h00);
    reg_read(6'h2C, rd);
    chk("midrst_bw_rate", rd, 8'h0A);
    chk("midrst_irq", bus.interrupt, 2'b00);
    chk("midrst_nopulse", wr_cnt, exp_wr);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
